func_param_ctrl: RTL and testbench

FUNC_PARAM_CTRL -- requirements
Module: func_param_ctrl

---
 rtl/func_param_ctrl.sv | 153 +++++++++++++++
 tb/tb_func_param_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/func_param_ctrl.sv
// Front-panel parameter controller: debounced keys adjust the frequency word,
// phase word and generator mode of a signal generator.
module func_param_ctrl #(
  parameter int         DEB_CYCLES = 1000,
  parameter logic [7:0] F_INIT     = 8'd1,
  parameter logic [7:0] F_MIN      = 8'd1,
  parameter logic [7:0] F_MAX      = 8'd255,
  parameter logic [7:0] P_STEP     = 8'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_f_up,
  input  logic       key_f_dn,
  input  logic       key_p,
  input  logic       key_mode,
  output logic [7:0] F_word,
  output logic [7:0] P_word,
  output logic [1:0] mode,
  output logic       squire_en,
  output logic       tri_en,
  output logic       sine_en,
  output logic       param_upd
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SQUARE = 2'd0,
    ST_TRI    = 2'd1,
    ST_SINE   = 2'd2,
    ST_OFF    = 2'd3
  } state_t;

  // key index: 0 = f_up, 1 = f_dn, 2 = p, 3 = mode
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_stable;
  logic [3:0]    r_stable_d;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_press;

  logic [7:0] r_f_word;
  logic [7:0] r_p_word;
  state_t     r_state;
  logic       r_squire_en;
  logic       r_tri_en;
  logic       r_sine_en;
  logic       r_param_upd;

  logic [7:0] w_f_next;
  logic [7:0] w_p_next;
  state_t     w_state_next;
  logic       w_upd;

  assign w_raw   = {key_mode, key_p, key_f_dn, key_f_up};
  assign w_press = r_stable & ~r_stable_d;

  // Synchronise and debounce each key; a level is accepted after DEB_CYCLES steady clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 4'b0000;
      r_sync2    <= 4'b0000;
      r_stable   <= 4'b0000;
      r_stable_d <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] != r_stable[k]) begin
          if (r_cnt[k] == CNT_LAST) begin
            r_stable[k] <= r_sync2[k];
            r_cnt[k]    <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  // Next parameter words; opposing frequency presses cancel, saturation suppresses change.
  always_comb begin
    w_f_next = r_f_word;
    w_p_next = r_p_word;
    if (w_press[0] && !w_press[1] && (r_f_word < F_MAX)) begin
      w_f_next = r_f_word + 8'd1;
    end else if (w_press[1] && !w_press[0] && (r_f_word > F_MIN)) begin
      w_f_next = r_f_word - 8'd1;
    end else begin
      w_f_next = r_f_word;
    end
    if (w_press[2]) begin
      w_p_next = r_p_word + P_STEP;
    end else begin
      w_p_next = r_p_word;
    end
    w_upd = (w_f_next != r_f_word) || (w_p_next != r_p_word);
  end

  // Mode sequencing on each mode press.
  always_comb begin
    w_state_next = r_state;
    if (w_press[3]) begin
      case (r_state)
        ST_SQUARE: w_state_next = ST_TRI;
        ST_TRI:    w_state_next = ST_SINE;
        ST_SINE:   w_state_next = ST_OFF;
        ST_OFF:    w_state_next = ST_SQUARE;
        default:   w_state_next = ST_SQUARE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Register parameter words, mode and one-hot enables together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_word    <= F_INIT;
      r_p_word    <= 8'd0;
      r_state     <= ST_SQUARE;
      r_squire_en <= 1'b1;
      r_tri_en    <= 1'b0;
      r_sine_en   <= 1'b0;
      r_param_upd <= 1'b0;
    end else begin
      r_f_word    <= w_f_next;
      r_p_word    <= w_p_next;
      r_state     <= w_state_next;
      r_squire_en <= (w_state_next == ST_SQUARE);
      r_tri_en    <= (w_state_next == ST_TRI);
      r_sine_en   <= (w_state_next == ST_SINE);
      r_param_upd <= w_upd;
    end
  end

  assign F_word    = r_f_word;
  assign P_word    = r_p_word;
  assign mode      = r_state;
  assign squire_en = r_squire_en;
  assign tri_en    = r_tri_en;
  assign sine_en   = r_sine_en;
  assign param_upd = r_param_upd;

endmodule

// File: tb/tb_func_param_ctrl.sv
// Directed, table-driven bench for func_param_ctrl with a short debounce window.
module tb_func_param_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_f_up, key_f_dn, key_p, key_mode;
  logic [7:0] F_word, P_word;
  logic [1:0] mode;
  logic       squire_en, tri_en, sine_en, param_upd;

  func_param_ctrl #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .key_f_up(key_f_up), .key_f_dn(key_f_dn), .key_p(key_p), .key_mode(key_mode),
    .F_word(F_word), .P_word(P_word), .mode(mode),
    .squire_en(squire_en), .tri_en(tri_en), .sine_en(sine_en),
    .param_upd(param_upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;   // {mode, p, f_dn, f_up}
    int         hold;
    logic [7:0] f;
    logic [7:0] p;
    logic [1:0] m;
    int         upd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   upd_cnt = 0;
  int   chg_edge;

  task automatic tick();
    @(posedge clk);
    #1;
    if (param_upd) upd_cnt++;
    if ($countones({squire_en, tri_en, sine_en}) > 1) begin
      n_err++;
      $display("FAIL onehot got %b%b%b required at most one high", squire_en, tri_en, sine_en);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_mode, key_p, key_f_dn, key_f_up} = k;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    set_keys(k);
    repeat (hold) tick();
    set_keys(4'b0000);
    repeat (8) tick();
  endtask

  task automatic expect_int(input string nm, input int got, input int exp);
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic check_state(input string nm, input logic [7:0] f, input logic [7:0] p,
                             input logic [1:0] m, input int upd);
    logic [2:0] en;
    case (m)
      2'd0:    en = 3'b100;
      2'd1:    en = 3'b010;
      2'd2:    en = 3'b001;
      default: en = 3'b000;
    endcase
    n_vec++;
    expect_int({nm, " F_word"}, int'(F_word), int'(f));
    expect_int({nm, " P_word"}, int'(P_word), int'(p));
    expect_int({nm, " mode"}, int'(mode), int'(m));
    expect_int({nm, " enables"}, int'({squire_en, tri_en, sine_en}), int'(en));
    expect_int({nm, " param_upd count"}, upd_cnt, upd);
  endtask

  task automatic do_reset();
    set_keys(4'b0000);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    upd_cnt = 0;
  endtask

  // Hold f_up from just before edge 1 and record the edge on which F_word first reads 2.
  task automatic measure_f_up_edge();
    chg_edge = 0;
    key_f_up = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (F_word == 8'd2 && chg_edge == 0) chg_edge = e;
    end
    key_f_up = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    tbl.push_back('{keys:4'b0000, hold:8,  f:8'd1, p:8'd0,   m:2'd0, upd:0});
    tbl.push_back('{keys:4'b0001, hold:10, f:8'd2, p:8'd0,   m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0001, hold:3,  f:8'd2, p:8'd0,   m:2'd0, upd:0});
    tbl.push_back('{keys:4'b0010, hold:8,  f:8'd1, p:8'd0,   m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0010, hold:8,  f:8'd1, p:8'd0,   m:2'd0, upd:0});
    tbl.push_back('{keys:4'b0011, hold:8,  f:8'd1, p:8'd0,   m:2'd0, upd:0});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd32,  m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd64,  m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd96,  m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd128, m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd160, m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd192, m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd224, m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd0,   m:2'd0, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd1, p:8'd32,  m:2'd0, upd:1});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd1, p:8'd32,  m:2'd1, upd:0});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd1, p:8'd32,  m:2'd2, upd:0});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd1, p:8'd32,  m:2'd3, upd:0});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd1, p:8'd32,  m:2'd0, upd:0});
    tbl.push_back('{keys:4'b1101, hold:8,  f:8'd2, p:8'd64,  m:2'd1, upd:1});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd2, p:8'd64,  m:2'd2, upd:0});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd2, p:8'd64,  m:2'd3, upd:0});
    tbl.push_back('{keys:4'b0001, hold:8,  f:8'd3, p:8'd64,  m:2'd3, upd:1});
    tbl.push_back('{keys:4'b0100, hold:8,  f:8'd3, p:8'd96,  m:2'd3, upd:1});
    tbl.push_back('{keys:4'b1000, hold:8,  f:8'd3, p:8'd96,  m:2'd0, upd:0});

    do_reset();
    check_state("reset", 8'd1, 8'd0, 2'd0, 0);

    foreach (tbl[i]) begin
      upd_cnt = 0;
      press(tbl[i].keys, tbl[i].hold);
      check_state($sformatf("vec%0d", i), tbl[i].f, tbl[i].p, tbl[i].m, tbl[i].upd);
    end

    // f_up latency: press must land on edge DEB_CYCLES+3 = 7.
    do_reset();
    measure_f_up_edge();
    n_vec++;
    expect_int("latency edge", chg_edge, 7);
    check_state("latency", 8'd2, 8'd0, 2'd0, 1);

    // Reset at counter = 2 with the key released: nothing registers.
    do_reset();
    key_f_up = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    key_f_up = 1'b0;
    tick();
    rst = 1'b0;
    upd_cnt = 0;
    repeat (12) tick();
    check_state("rst mid-debounce", 8'd1, 8'd0, 2'd0, 0);

    // Key held through reset: counted afresh from the first non-reset edge.
    key_f_up = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd_cnt = 0;
    key_f_up = 1'b0;
    measure_f_up_edge();
    n_vec++;
    expect_int("held through reset edge", chg_edge, 7);
    check_state("held through reset", 8'd2, 8'd0, 2'd0, 1);

    // Preload to the upper bound, then one more press must saturate silently.
    do_reset();
    for (int n = 0; n < 254; n++) press(4'b0001, 8);
    check_state("preload 255", 8'd255, 8'd0, 2'd0, 254);
    upd_cnt = 0;
    press(4'b0001, 8);
    check_state("saturate max", 8'd255, 8'd0, 2'd0, 0);
    press(4'b0010, 8);
    check_state("step down from max", 8'd254, 8'd0, 2'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
